// File: rtl/m_switch_allocator_vc_if.sv
// Request/grant bundle between VC buffers, the switch allocator and the crossbar.
// master = upstream requester / crossbar side, slave = allocator.
interface m_switch_allocator_vc_if #(
   parameter int P_PORTS = 5,
   parameter int P_VCS   = 2
);
   localparam int OW = $clog2(P_PORTS);
   localparam int VW = (P_VCS > 1) ? $clog2(P_VCS) : 1;
   localparam int NV = P_PORTS * P_VCS;

   logic [NV-1:0]         req;
   logic [NV*OW-1:0]      req_out;
   logic [NV-1:0]         req_tail;
   logic [P_PORTS-1:0]    out_ready;
   logic [NV-1:0]         gnt;
   logic [P_PORTS-1:0]    out_valid;
   logic [P_PORTS*OW-1:0] out_sel;
   logic [P_PORTS*VW-1:0] out_vc;

   modport master (
      output req, req_out, req_tail, out_ready,
      input  gnt, out_valid, out_sel, out_vc
   );

   modport slave (
      input  req, req_out, req_tail, out_ready,
      output gnt, out_valid, out_sel, out_vc
   );
endinterface

// File: rtl/m_switch_allocator_vc.sv
// Separable VC switch allocator: per-input RR over VCs, per-output RR over inputs,
// per-output head..tail packet locking, credit gating and registered grants.
module m_switch_allocator_vc #(
   parameter int P_ROUTER_ID = 0,
   parameter int P_PORTS     = 5,
   parameter int P_VCS       = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   m_switch_allocator_vc_if.slave s_if
);
   localparam int OW = $clog2(P_PORTS);
   localparam int VW = (P_VCS > 1) ? $clog2(P_VCS) : 1;
   localparam int NV = P_PORTS * P_VCS;
   localparam logic [OW:0] LP_NP = (OW+1)'(P_PORTS);

   typedef enum logic {FREE, LOCKED} lock_state_t;

   lock_state_t           r_state     [P_PORTS];
   lock_state_t           w_state_nxt [P_PORTS];
   logic [OW-1:0]         r_lock_in   [P_PORTS];
   logic [VW-1:0]         r_lock_vc   [P_PORTS];
   logic [OW-1:0]         r_in_ptr    [P_PORTS];
   logic [VW-1:0]         r_vc_ptr    [P_PORTS];
   logic [P_PORTS-1:0]    w_locked;

   logic [NV-1:0]         w_elig;
   logic [NV-1:0]         w_own;
   logic [P_PORTS-1:0]    w_s1_vld;
   logic [VW-1:0]         w_s1_vc  [P_PORTS];
   logic [OW-1:0]         w_s1_out [P_PORTS];
   logic [P_PORTS-1:0]    w_o_vld;
   logic [OW-1:0]         w_o_in   [P_PORTS];
   logic [VW-1:0]         w_o_vc   [P_PORTS];
   logic [P_PORTS-1:0]    w_o_tail;
   logic [NV-1:0]         w_gnt;

   logic [NV-1:0]         r_gnt;
   logic [P_PORTS-1:0]    r_out_valid;
   logic [P_PORTS*OW-1:0] r_out_sel;
   logic [P_PORTS*VW-1:0] r_out_vc;

   // Lock FSM per output: state register, next state, outputs
   always_ff @(posedge i_clk) begin
      for (int unsigned o = 0; o < P_PORTS; o++)
         r_state[o] <= i_rst ? FREE : w_state_nxt[o];
   end

   always_comb begin
      for (int unsigned o = 0; o < P_PORTS; o++) begin
         w_state_nxt[o] = r_state[o];
         if (w_o_vld[o]) begin
            case (r_state[o])
               FREE:    if (!w_o_tail[o]) w_state_nxt[o] = LOCKED;
               LOCKED:  if (w_o_tail[o])  w_state_nxt[o] = FREE;
               default: w_state_nxt[o] = FREE;
            endcase
         end
      end
   end

   always_comb begin
      for (int unsigned o = 0; o < P_PORTS; o++)
         w_locked[o] = (r_state[o] == LOCKED);
   end

   // Out-of-range destinations fail the range test before any indexed lookup matters
   always_comb begin
      logic [OW-1:0] dst;
      dst    = '0;
      w_elig = '0;
      w_own  = '0;
      for (int unsigned i = 0; i < P_PORTS; i++) begin
         for (int unsigned v = 0; v < P_VCS; v++) begin
            dst = s_if.req_out[(i*P_VCS+v)*OW +: OW];
            if (s_if.req[i*P_VCS+v] && ({1'b0, dst} < LP_NP) && s_if.out_ready[dst] &&
                (!w_locked[dst] || (r_lock_in[dst] == OW'(i) && r_lock_vc[dst] == VW'(v))))
               w_elig[i*P_VCS+v] = 1'b1;
            for (int unsigned o = 0; o < P_PORTS; o++)
               if (w_locked[o] && r_lock_in[o] == OW'(i) && r_lock_vc[o] == VW'(v))
                  w_own[i*P_VCS+v] = 1'b1;
         end
      end
   end

   // Stage 1: an eligible lock-owner VC pre-empts the round-robin choice of its input
   always_comb begin
      logic [P_VCS-1:0] m;
      int unsigned      v;
      m = '0;
      v = 0;
      for (int unsigned i = 0; i < P_PORTS; i++) begin
         w_s1_vld[i] = 1'b0;
         w_s1_vc[i]  = '0;
         m = w_elig[i*P_VCS +: P_VCS] & w_own[i*P_VCS +: P_VCS];
         if (m == '0)
            m = w_elig[i*P_VCS +: P_VCS];
         for (int unsigned k = 0; k < P_VCS; k++) begin
            v = (32'(r_vc_ptr[i]) + k) % 32'(P_VCS);
            if (!w_s1_vld[i] && m[v]) begin
               w_s1_vld[i] = 1'b1;
               w_s1_vc[i]  = VW'(v);
            end
         end
         w_s1_out[i] = s_if.req_out[(i*P_VCS + 32'(w_s1_vc[i]))*OW +: OW];
      end
   end

   // Stage 2: per-output round-robin over inputs whose stage-1 winner targets it
   always_comb begin
      int unsigned ii;
      ii    = 0;
      w_gnt = '0;
      for (int unsigned o = 0; o < P_PORTS; o++) begin
         w_o_vld[o]  = 1'b0;
         w_o_in[o]   = '0;
         w_o_vc[o]   = '0;
         w_o_tail[o] = 1'b0;
         for (int unsigned k = 0; k < P_PORTS; k++) begin
            ii = (32'(r_in_ptr[o]) + k) % 32'(P_PORTS);
            if (!w_o_vld[o] && w_s1_vld[ii] && w_s1_out[ii] == OW'(o)) begin
               w_o_vld[o]  = 1'b1;
               w_o_in[o]   = OW'(ii);
               w_o_vc[o]   = w_s1_vc[ii];
               w_o_tail[o] = s_if.req_tail[ii*P_VCS + 32'(w_s1_vc[ii])];
            end
         end
         if (w_o_vld[o])
            w_gnt[32'(w_o_in[o])*P_VCS + 32'(w_o_vc[o])] = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_gnt       <= '0;
         r_out_valid <= '0;
         r_out_sel   <= '0;
         r_out_vc    <= '0;
         for (int unsigned o = 0; o < P_PORTS; o++) begin
            r_in_ptr[o]  <= '0;
            r_vc_ptr[o]  <= '0;
            r_lock_in[o] <= '0;
            r_lock_vc[o] <= '0;
         end
      end else begin
         r_gnt       <= w_gnt;
         r_out_valid <= w_o_vld;
         for (int unsigned o = 0; o < P_PORTS; o++) begin
            r_out_sel[o*OW +: OW] <= w_o_in[o];
            r_out_vc[o*VW +: VW]  <= w_o_vc[o];
            if (w_o_vld[o]) begin
               r_in_ptr[o] <= (w_o_in[o] == OW'(P_PORTS-1)) ? '0 : w_o_in[o] + 1'b1;
               r_vc_ptr[w_o_in[o]] <= (w_o_vc[o] == VW'(P_VCS-1)) ? '0 : w_o_vc[o] + 1'b1;
               if (r_state[o] == FREE && !w_o_tail[o]) begin
                  r_lock_in[o] <= w_o_in[o];
                  r_lock_vc[o] <= w_o_vc[o];
               end
            end
         end
      end
   end

   assign s_if.gnt       = r_gnt;
   assign s_if.out_valid = r_out_valid;
   assign s_if.out_sel   = r_out_sel;
   assign s_if.out_vc    = r_out_vc;
endmodule
